// File: rtl/kmeans_regfile_apb.sv
// kmeans_regfile_apb: APB register file for the k-means accelerator.
// Holds the centroid registers, the run control towards the core (start/done)
// and an indirect RAM write port with a req/ack handshake.
// Optional build macro KM_IRQ_EN: enables the done interrupt and IRQ_EN register.
//
// state     | meaning
// A_IDLE    | APB waiting for a setup phase
// A_ACCESS  | pready high for one cycle, prdata/pslverr valid
// A_WAIT    | RAM_DATA write held until the outstanding RAM request is acked
// R_IDLE    | core idle
// R_RUN     | core running, configuration writes locked
// R_DONE    | core finished, done flag visible in STATUS
module kmeans_regfile_apb #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 91,
    parameter int NUM_CENT = 8,
    parameter int CIDX_W   = (NUM_CENT > 1) ? $clog2(NUM_CENT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              core_start,
    output logic              core_busy,
    input  logic              core_done,
    input  logic [CIDX_W-1:0] core_ridx,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              core_we,
    input  logic [CIDX_W-1:0] core_widx,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [ADDR_W-1:0] first_addr,
    output logic [ADDR_W-1:0] last_addr,
    output logic              ram_wr_req,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic              ram_wr_ack,
    output logic              irq
);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'('h01);
    localparam logic [ADDR_W-1:0] A_RAM_ADDR = ADDR_W'('h20);
    localparam logic [ADDR_W-1:0] A_RAM_DATA = ADDR_W'('h21);
    localparam logic [ADDR_W-1:0] A_FIRST    = ADDR_W'('h22);
    localparam logic [ADDR_W-1:0] A_LAST     = ADDR_W'('h23);
    localparam logic [ADDR_W-1:0] A_IRQ_EN   = ADDR_W'('h24);

    typedef enum logic [1:0] {A_IDLE, A_ACCESS, A_WAIT} apb_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} run_state_t;

    apb_state_t        apb_state;
    run_state_t        run_state;
    logic [DATA_W-1:0] cent [NUM_CENT];
    logic [ADDR_W-1:0] ram_addr;
    logic              err;
`ifdef KM_IRQ_EN
    logic              irq_en;
`endif

    logic              running, range_ok, setup, stall;
    logic              cent_hit, unmapped, wr_blocked, go_bad, acc_err;
    logic [CIDX_W-1:0] cent_idx;
    logic [DATA_W-1:0] rd_val;
    logic [31:0]       paddr_ext, widx_ext, ridx_ext;

    assign running   = (run_state == R_RUN);
    assign core_busy = running;
    assign range_ok  = (first_addr <= last_addr);
    assign setup     = (apb_state == A_IDLE) && psel && !penable;
    assign paddr_ext = 32'(paddr);
    assign widx_ext  = 32'(core_widx);
    assign ridx_ext  = 32'(core_ridx);
    assign acc_err   = unmapped || (pwrite && wr_blocked);
    // A RAM_DATA write only stalls when it would otherwise be legal.
    assign stall     = pwrite && !acc_err && (paddr == A_RAM_DATA) && ram_wr_req;

    // Address decode: read value, unmapped flag and write-lock per register.
    always_comb begin
        cent_idx   = CIDX_W'(paddr_ext - 32'd2);
        cent_hit   = (paddr_ext >= 32'd2) && (paddr_ext < 32'd2 + 32'(NUM_CENT));
        rd_val     = '0;
        unmapped   = 1'b0;
        wr_blocked = 1'b0;
        go_bad     = 1'b0;
        if (cent_hit) begin
            rd_val     = cent[cent_idx];
            wr_blocked = running;
        end else begin
            case (paddr)
                A_STATUS:   rd_val = DATA_W'({err, ram_wr_req, run_state == R_DONE, running});
                A_CTRL: begin
                    go_bad     = pwdata[0] && (running || !range_ok);
                    wr_blocked = go_bad;
                end
                A_RAM_ADDR: begin
                    rd_val     = DATA_W'(ram_addr);
                    wr_blocked = running;
                end
                A_RAM_DATA: begin
                    rd_val     = ram_wr_data;
                    wr_blocked = running;
                end
                A_FIRST: begin
                    rd_val     = DATA_W'(first_addr);
                    wr_blocked = running;
                end
                A_LAST: begin
                    rd_val     = DATA_W'(last_addr);
                    wr_blocked = running;
                end
                A_IRQ_EN: begin
`ifdef KM_IRQ_EN
                    rd_val = DATA_W'(irq_en);
`endif
                end
                default:    unmapped = 1'b1;
            endcase
        end
    end

    // APB handshake, register writes, run control and RAM request tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            apb_state   <= A_IDLE;
            run_state   <= R_IDLE;
            prdata      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            core_start  <= 1'b0;
            err         <= 1'b0;
            first_addr  <= '0;
            last_addr   <= '0;
            ram_addr    <= '0;
            ram_wr_req  <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
`ifdef KM_IRQ_EN
            irq_en      <= 1'b0;
`endif
            for (int i = 0; i < NUM_CENT; i++) cent[i] <= '0;
        end else begin
            pready     <= 1'b0;
            core_start <= 1'b0;

            if (ram_wr_req && ram_wr_ack) begin
                ram_wr_req <= 1'b0;
                ram_addr   <= ram_addr + 1'b1;
            end

            if (running && core_we && (widx_ext < 32'(NUM_CENT)))
                cent[core_widx] <= core_wdata;

            if (running && core_done)
                run_state <= R_DONE;

            case (apb_state)
                A_IDLE: begin
                    if (setup) begin
                        if (stall) begin
                            apb_state <= A_WAIT;
                        end else begin
                            apb_state <= A_ACCESS;
                            pready    <= 1'b1;
                            pslverr   <= acc_err;
                            prdata    <= pwrite ? '0 : rd_val;
                            if (pwrite && go_bad && !running)
                                err <= 1'b1;
                            if (pwrite && !acc_err) begin
                                if (cent_hit) begin
                                    cent[cent_idx] <= pwdata;
                                end else begin
                                    case (paddr)
                                        A_CTRL: begin
                                            if (pwdata[0]) begin
                                                run_state  <= R_RUN;
                                                core_start <= 1'b1;
                                            end else if (pwdata[1] && run_state == R_DONE) begin
                                                run_state <= R_IDLE;
                                            end
                                            if (pwdata[2])
                                                err <= 1'b0;
                                        end
                                        A_RAM_ADDR: ram_addr   <= pwdata[ADDR_W-1:0];
                                        A_RAM_DATA: begin
                                            ram_wr_addr <= ram_addr;
                                            ram_wr_data <= pwdata;
                                            ram_wr_req  <= 1'b1;
                                        end
                                        A_FIRST:    first_addr <= pwdata[ADDR_W-1:0];
                                        A_LAST:     last_addr  <= pwdata[ADDR_W-1:0];
                                        A_IRQ_EN: begin
`ifdef KM_IRQ_EN
                                            irq_en <= pwdata[0];
`endif
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                end
                A_ACCESS: apb_state <= A_IDLE;
                A_WAIT: begin
                    // Previous request was acked last edge; issue the held write now.
                    if (!ram_wr_req) begin
                        ram_wr_addr <= ram_addr;
                        ram_wr_data <= pwdata;
                        ram_wr_req  <= 1'b1;
                        apb_state   <= A_ACCESS;
                        pready      <= 1'b1;
                        pslverr     <= 1'b0;
                        prdata      <= '0;
                    end
                end
                default: apb_state <= A_IDLE;
            endcase
        end
    end

    // Core-side centroid read, one cycle latency, out-of-range index reads 0.
    always_ff @(posedge clk) begin
        if (rst)
            core_rdata <= '0;
        else if (ridx_ext < 32'(NUM_CENT))
            core_rdata <= cent[core_ridx];
        else
            core_rdata <= '0;
    end

`ifdef KM_IRQ_EN
    // Done interrupt, gated by IRQ_EN.
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= (run_state == R_DONE) && irq_en;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_regfile_apb.sv
// Self-checking bench for kmeans_regfile_apb against a register-level model.
module tb_kmeans_regfile_apb;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 91;
    localparam int NUM_CENT = 8;
    localparam int CIDX_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              pready, pslverr;
    logic              core_start, core_busy, core_done;
    logic [CIDX_W-1:0] core_ridx, core_widx;
    logic [DATA_W-1:0] core_rdata, core_wdata;
    logic              core_we;
    logic [ADDR_W-1:0] first_addr, last_addr;
    logic              ram_wr_req;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_wr_ack;
    logic              irq;

    kmeans_regfile_apb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CENT(NUM_CENT), .CIDX_W(CIDX_W)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_ridx(core_ridx), .core_rdata(core_rdata), .core_we(core_we),
        .core_widx(core_widx), .core_wdata(core_wdata), .first_addr(first_addr),
        .last_addr(last_addr), .ram_wr_req(ram_wr_req), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_wr_ack(ram_wr_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Counts cycles in which core_start is high.
    always @(negedge clk) if (core_start === 1'b1) start_cnt++;

    // Reference model state
    logic [DATA_W-1:0] m_cent [NUM_CENT];
    logic [7:0]        m_first, m_last, m_ram_addr;
    logic              m_busy, m_done, m_err, m_req, m_irq_en;

    task automatic model_reset();
        for (int i = 0; i < NUM_CENT; i++) m_cent[i] = '0;
        m_first = 0; m_last = 0; m_ram_addr = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_irq_en = 0;
    endtask

    function automatic logic [DATA_W-1:0] rand91();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[90:0];
    endfunction

    function automatic logic exp_unmapped(input int a);
        return !(a == 0 || a == 1 || (a >= 2 && a < 2 + NUM_CENT) || (a >= 'h20 && a <= 'h24));
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input int a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a == 0) v = DATA_W'({m_err, m_req, m_done, m_busy});
        else if (a >= 2 && a < 2 + NUM_CENT) v = m_cent[a-2];
        else if (a == 'h20) v = DATA_W'(m_ram_addr);
        else if (a == 'h22) v = DATA_W'(m_first);
        else if (a == 'h23) v = DATA_W'(m_last);
`ifdef KM_IRQ_EN
        else if (a == 'h24) v = DATA_W'(m_irq_en);
`endif
        return v;
    endfunction

    function automatic logic exp_irq();
`ifdef KM_IRQ_EN
        return m_done && m_irq_en;
`else
        return 1'b0;
`endif
    endfunction

    task automatic apb_xfer(input logic [7:0] a, input logic wr, input logic [DATA_W-1:0] wd,
                            output logic [DATA_W-1:0] rd, output logic e, output int waited);
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = a; pwrite = wr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1;
        waited = 0;
        while (pready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (pready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h pready=%b required=1", a, pready);
        end
        rd = prdata;
        e  = pslverr;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_wr(input int a, input logic [DATA_W-1:0] d, output logic e);
        logic [DATA_W-1:0] rd;
        int w;
        apb_xfer(8'(a), 1'b1, d, rd, e, w);
    endtask

    task automatic apb_rd(input int a, output logic [DATA_W-1:0] rd, output logic e);
        int w;
        apb_xfer(8'(a), 1'b0, '0, rd, e, w);
    endtask

    task automatic pulse_done();
        core_done = 1; @(posedge clk); #1; core_done = 0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] rd;
        logic e;
        rst = 1; repeat (2) @(posedge clk); #1; rst = 0;
        model_reset();
        checks++;
        if ({pready, pslverr, core_start, core_busy, ram_wr_req, irq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_outputs got=%b required=000000",
                     {pready, pslverr, core_start, core_busy, ram_wr_req, irq});
        end
        checks++;
        if (prdata !== '0 || first_addr !== '0 || last_addr !== '0 || core_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data_outputs prdata=%h first=%h last=%h rdata=%h required=0",
                     prdata, first_addr, last_addr, core_rdata);
        end
        for (int a = 0; a <= 'h24; a++) begin
            apb_rd(a, rd, e);
            checks++;
            if (rd !== '0 || e !== exp_unmapped(a)) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h err=%b required=0 err=%b", a, rd, e, exp_unmapped(a));
            end
        end
        apb_rd('h30, rd, e);
        checks++;
        if (rd !== '0 || e !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read got=%h err=%b required=0 err=1", rd, e);
        end
    endtask

    task automatic test_reg_random();
        logic [DATA_W-1:0] rd, d;
        logic e;
        int a, ra;
        int readable[$];
        readable = {0, 'h20, 'h22, 'h23, 'h24};
        for (int i = 0; i < NUM_CENT; i++) readable.push_back(2 + i);
        repeat (40) begin
            d = rand91();
            case ($urandom_range(0, 4))
                0: begin a = 2 + $urandom_range(0, NUM_CENT - 1); m_cent[a-2] = d; end
                1: begin a = 'h22; m_first = d[7:0]; end
                2: begin a = 'h23; m_last = d[7:0]; end
                3: begin a = 'h20; m_ram_addr = d[7:0]; end
                default: begin
                    a = 'h24;
`ifdef KM_IRQ_EN
                    m_irq_en = d[0];
`endif
                end
            endcase
            apb_wr(a, d, e);
            checks++;
            if (e !== 1'b0) begin
                errors++;
                $display("FAIL reg_write_err addr=%h got=%b required=0", a, e);
            end
            ra = readable[$urandom_range(0, readable.size() - 1)];
            apb_rd(ra, rd, e);
            checks++;
            if (rd !== exp_read(ra) || e !== 1'b0) begin
                errors++;
                $display("FAIL reg_read addr=%h got=%h err=%b required=%h err=0", ra, rd, e, exp_read(ra));
            end
        end
        // Unmapped writes: error, no state change
        repeat (8) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(2 + NUM_CENT, 'h1F) : $urandom_range('h25, 'hFF);
            apb_wr(a, rand91(), e);
            checks++;
            if (e !== 1'b1) begin
                errors++;
                $display("FAIL unmapped_write addr=%h err=%b required=1", a, e);
            end
        end
        foreach (readable[i]) begin
            apb_rd(readable[i], rd, e);
            checks++;
            if (rd !== exp_read(readable[i])) begin
                errors++;
                $display("FAIL reg_after_unmapped addr=%h got=%h required=%h", readable[i], rd, exp_read(readable[i]));
            end
        end
    endtask

    task automatic test_run();
        logic [DATA_W-1:0] rd, d;
        logic e;
        int s0, idx;
        apb_wr(5, DATA_W'('h1234), e); m_cent[3] = DATA_W'('h1234);
        apb_wr('h22, DATA_W'(2), e); m_first = 2;
        apb_wr('h23, DATA_W'(9), e); m_last = 9;
        apb_wr('h24, DATA_W'(1), e);
`ifdef KM_IRQ_EN
        m_irq_en = 1;
`endif
        s0 = start_cnt;
        apb_wr(1, DATA_W'(1), e); m_busy = 1;
        checks++;
        if (e !== 1'b0 || start_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL go_start err=%b pulses=%0d required err=0 pulses=1", e, start_cnt - s0);
        end
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || core_busy !== 1'b1) begin
            errors++;
            $display("FAIL status_run got=%h busy=%b required=%h busy=1", rd, core_busy, exp_read(0));
        end
        core_ridx = 3; @(posedge clk); #1;
        checks++;
        if (core_rdata !== m_cent[3]) begin
            errors++;
            $display("FAIL core_read got=%h required=%h", core_rdata, m_cent[3]);
        end
        // Locked writes in RUN
        s0 = start_cnt;
        apb_wr(2, rand91(), e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL run_cent_write err=%b required=1", e); end
        apb_wr('h22, DATA_W'(0), e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL run_first_write err=%b required=1", e); end
        apb_wr(1, DATA_W'(1), e);
        checks++;
        if (e !== 1'b1 || start_cnt !== s0) begin
            errors++;
            $display("FAIL run_go err=%b pulses=%0d required err=1 pulses=0", e, start_cnt - s0);
        end
        apb_rd(2, rd, e);
        checks++;
        if (rd !== m_cent[0] || first_addr !== m_first) begin
            errors++;
            $display("FAIL run_locked cent0=%h first=%h required=%h first=%h", rd, first_addr, m_cent[0], m_first);
        end
        // Core write idx 0
        core_we = 1; core_widx = 0; core_wdata = DATA_W'('hAB);
        @(posedge clk); #1; core_we = 0; m_cent[0] = DATA_W'('hAB);
        apb_rd(2, rd, e);
        checks++;
        if (rd !== m_cent[0]) begin errors++; $display("FAIL core_write got=%h required=%h", rd, m_cent[0]); end
        // Random core writes with same-index read: old value then new value
        repeat (6) begin
            idx = $urandom_range(0, NUM_CENT - 1);
            d = rand91();
            core_we = 1; core_widx = CIDX_W'(idx); core_wdata = d; core_ridx = CIDX_W'(idx);
            @(posedge clk); #1; core_we = 0;
            checks++;
            if (core_rdata !== m_cent[idx]) begin
                errors++;
                $display("FAIL core_rd_old idx=%0d got=%h required=%h", idx, core_rdata, m_cent[idx]);
            end
            m_cent[idx] = d;
            @(posedge clk); #1;
            checks++;
            if (core_rdata !== d) begin
                errors++;
                $display("FAIL core_rd_new idx=%0d got=%h required=%h", idx, core_rdata, d);
            end
        end
        pulse_done(); m_busy = 0; m_done = 1;
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || irq !== exp_irq()) begin
            errors++;
            $display("FAIL status_done got=%h irq=%b required=%h irq=%b", rd, irq, exp_read(0), exp_irq());
        end
        // Outside RUN: core write and core_done ignored
        core_we = 1; core_widx = 1; core_wdata = rand91();
        @(posedge clk); #1; core_we = 0;
        pulse_done();
        apb_rd(3, rd, e);
        checks++;
        if (rd !== m_cent[1]) begin errors++; $display("FAIL done_core_write got=%h required=%h", rd, m_cent[1]); end
        // GO from DONE restarts directly
        s0 = start_cnt;
        apb_wr(1, DATA_W'(1), e); m_busy = 1; m_done = 0;
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || start_cnt !== s0 + 1 || irq !== exp_irq()) begin
            errors++;
            $display("FAIL done_go status=%h pulses=%0d irq=%b required=%h pulses=1 irq=%b",
                     rd, start_cnt - s0, irq, exp_read(0), exp_irq());
        end
        pulse_done(); m_busy = 0; m_done = 1;
        apb_wr(1, DATA_W'(2), e); m_done = 0;
        pulse_done();
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || irq !== exp_irq()) begin
            errors++;
            $display("FAIL done_clr status=%h irq=%b required=%h irq=%b", rd, irq, exp_read(0), exp_irq());
        end
    endtask

    task automatic test_ram();
        logic [DATA_W-1:0] rd, d;
        logic e;
        int w, dly;
        logic [7:0] ad;
        apb_wr('h20, DATA_W'('hFF), e); m_ram_addr = 8'hFF;
        apb_wr('h21, DATA_W'('h55), e); m_req = 1;
        checks++;
        if (e !== 1'b0 || ram_wr_req !== 1'b1 || ram_wr_addr !== 8'hFF || ram_wr_data !== DATA_W'('h55)) begin
            errors++;
            $display("FAIL ram_first err=%b req=%b addr=%h data=%h required 0 1 ff 55", e, ram_wr_req, ram_wr_addr, ram_wr_data);
        end
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0)) begin errors++; $display("FAIL status_pending got=%h required=%h", rd, exp_read(0)); end
        fork
            apb_xfer(8'h21, 1'b1, DATA_W'('h66), rd, e, w);
            begin
                repeat (3) @(posedge clk);
                #1; ram_wr_ack = 1;
                @(posedge clk); #1; ram_wr_ack = 0;
            end
        join
        m_ram_addr = 8'h00;
        checks++;
        if (w < 1 || e !== 1'b0 || ram_wr_req !== 1'b1 || ram_wr_addr !== 8'h00 || ram_wr_data !== DATA_W'('h66)) begin
            errors++;
            $display("FAIL ram_stall_wrap waited=%0d err=%b req=%b addr=%h data=%h required waited>0 0 1 00 66",
                     w, e, ram_wr_req, ram_wr_addr, ram_wr_data);
        end
        ram_wr_ack = 1; @(posedge clk); #1; ram_wr_ack = 0; m_req = 0; m_ram_addr = 8'h01;
        ram_wr_ack = 1; @(posedge clk); #1; ram_wr_ack = 0;
        apb_rd('h20, rd, e);
        checks++;
        if (rd !== exp_read('h20) || ram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL ram_ack_inc addr=%h req=%b required=%h req=0", rd, ram_wr_req, exp_read('h20));
        end
        // RAM writes locked during RUN
        apb_wr('h22, DATA_W'(0), e); m_first = 0;
        apb_wr('h23, DATA_W'(255), e); m_last = 255;
        apb_wr(1, DATA_W'(1), e); m_busy = 1;
        apb_wr('h21, rand91(), e);
        checks++;
        if (e !== 1'b1 || ram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL run_ram_write err=%b req=%b required err=1 req=0", e, ram_wr_req);
        end
        pulse_done(); m_busy = 0; m_done = 1;
        apb_wr(1, DATA_W'(2), e); m_done = 0;
        // Randomized RAM writes with random ack latency
        repeat (5) begin
            ad = 8'($urandom_range(0, 255));
            d = rand91();
            apb_wr('h20, DATA_W'(ad), e);
            apb_wr('h21, d, e);
            checks++;
            if (ram_wr_req !== 1'b1 || ram_wr_addr !== ad || ram_wr_data !== d) begin
                errors++;
                $display("FAIL ram_rand_issue req=%b addr=%h data=%h required 1 %h %h", ram_wr_req, ram_wr_addr, ram_wr_data, ad, d);
            end
            dly = $urandom_range(0, 3);
            repeat (dly) begin @(posedge clk); #1; end
            ram_wr_ack = 1; @(posedge clk); #1; ram_wr_ack = 0;
            m_ram_addr = ad + 8'd1;
            apb_rd('h20, rd, e);
            checks++;
            if (rd !== exp_read('h20) || ram_wr_req !== 1'b0) begin
                errors++;
                $display("FAIL ram_rand_ack addr=%h req=%b required=%h req=0", rd, ram_wr_req, exp_read('h20));
            end
        end
    endtask

    task automatic test_bad_range();
        logic [DATA_W-1:0] rd;
        logic e;
        int s0;
        apb_wr('h22, DATA_W'(5), e); m_first = 5;
        apb_wr('h23, DATA_W'(4), e); m_last = 4;
        s0 = start_cnt;
        apb_wr(1, DATA_W'(1), e); m_err = 1;
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || start_cnt !== s0 || core_busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_range status=%h pulses=%0d busy=%b required=%h pulses=0 busy=0",
                     rd, start_cnt - s0, core_busy, exp_read(0));
        end
        apb_wr(1, DATA_W'(1), e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL bad_range_err err=%b required=1", e); end
        apb_wr(1, DATA_W'(4), e); m_err = 0;
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0)) begin errors++; $display("FAIL err_clr got=%h required=%h", rd, exp_read(0)); end
        // FIRST == LAST is a valid range
        apb_wr('h22, DATA_W'(7), e); m_first = 7;
        apb_wr('h23, DATA_W'(7), e); m_last = 7;
        s0 = start_cnt;
        apb_wr(1, DATA_W'(1), e); m_busy = 1;
        apb_rd(0, rd, e);
        checks++;
        if (rd !== exp_read(0) || start_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL equal_range status=%h pulses=%0d required=%h pulses=1", rd, start_cnt - s0, exp_read(0));
        end
        pulse_done(); m_busy = 0; m_done = 1;
        apb_wr(1, DATA_W'(2), e); m_done = 0;
    endtask

    task automatic test_reset_midrun();
        logic [DATA_W-1:0] rd;
        logic e;
        apb_wr('h20, DATA_W'('h10), e);
        apb_wr('h21, rand91(), e);
        apb_wr('h22, DATA_W'(1), e);
        apb_wr('h23, DATA_W'(3), e);
        apb_wr(1, DATA_W'(1), e);
        checks++;
        if (core_busy !== 1'b1 || ram_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset busy=%b req=%b required busy=1 req=1", core_busy, ram_wr_req);
        end
        rst = 1; @(posedge clk); #1;
        checks++;
        if (core_busy !== 1'b0 || ram_wr_req !== 1'b0 || first_addr !== '0 || last_addr !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset busy=%b req=%b first=%h last=%h irq=%b required all 0",
                     core_busy, ram_wr_req, first_addr, last_addr, irq);
        end
        rst = 0;
        model_reset();
        for (int a = 0; a <= 'h24; a++) begin
            if (!exp_unmapped(a)) begin
                apb_rd(a, rd, e);
                checks++;
                if (rd !== '0 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL midrun_reset_read addr=%h got=%h err=%b required=0 err=0", a, rd, e);
                end
            end
        end
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        core_done = 0; core_ridx = '0; core_we = 0; core_widx = '0; core_wdata = '0;
        ram_wr_ack = 0;
        model_reset();
        test_reset();
        test_reg_random();
        test_run();
        test_ram();
        test_bad_range();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
